// File: rtl/led7seg_pkg.sv
// led7seg_pkg: shared types and helpers for the 7-segment scan driver.
// Holds the scan FSM state enum, the hex-to-segment table and the
// active-high segment helper constants used by the decoder and the top.
package led7seg_pkg;

    // Scan slot phases: all-dark dead time, then the digit is driven.
    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Active-high segment patterns (bit6..0 = g,f,e,d,c,b,a).
    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_ON  = 7'h7F;

    // Hex digit to active-high segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    // Convert an active-high pattern to pin level for the given polarity.
    function automatic logic [6:0] seg_pins(input logic [6:0] seg_ah, input logic active_low);
        return active_low ? (seg_ah ^ SEG_ON) : seg_ah;
    endfunction

endpackage

// File: rtl/led7seg_scan_decode.sv
// led7seg_scan_decode: combinational nibble-to-segment-pin map.
// When enable_i is low the output is the dark pattern at pin polarity.
module led7seg_scan_decode
    import led7seg_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble_i,
    input  logic       enable_i,
    output logic [6:0] seg_o
);

    localparam logic SEG_POL_LOW = (SEG_ACTIVE_LOW != 0);

    // Look up the glyph, blank it when disabled, then apply pin polarity.
    always_comb begin
        seg_o = seg_pins(enable_i ? hex_to_seg(nibble_i) : SEG_OFF, SEG_POL_LOW);
    end

endmodule

// File: rtl/led7seg_scan.sv
// led7seg_scan: time-multiplexed driver for a bank of 7-segment digits.
// Each digit slot is SCAN_DIV cycles: GAP_CYCLES all-dark, then DRIVE.
// The displayed nibble/mask is latched once per slot so a load never
// tears the digit currently shown. Outputs are registered.
// Optional feature: define LED7SEG_SCAN_DP_EN to add the decimal point
// input dp and output seg_dp (captured and masked like the segments).
module led7seg_scan
    import led7seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1024,
    parameter int GAP_CYCLES     = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel
`ifdef LED7SEG_SCAN_DP_EN
    ,
    input  logic [DIGITS-1:0]     dp,
    output logic                  seg_dp
`endif
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]     GAP_LAST   = PW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic              SEG_POL_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_DARK   = seg_pins(SEG_OFF, SEG_POL_LOW);

    // Shadow registers written by load.
    logic [4*DIGITS-1:0] shadow_data_q;
    logic [DIGITS-1:0]   shadow_mask_q;

    // Scan control.
    scan_state_e         state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                sample_en;

    // Per-slot display latch.
    logic [3:0]          cur_nib;
    logic                cur_mask;
    logic [3:0]          disp_nib_q;
    logic                disp_mask_q;

    // Output stage.
    logic                drive_on;
    logic [6:0]          segments_d, segments_q;
    logic [DIGITS-1:0]   digit_sel_d, digit_sel_q;

`ifdef LED7SEG_SCAN_DP_EN
    logic [DIGITS-1:0]   shadow_dp_q;
    logic                cur_dp;
    logic                disp_dp_q;
    logic                seg_dp_d, seg_dp_q;
`endif

    // Capture the host word on the load strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
        end else if (load) begin
            shadow_data_q <= data;
            shadow_mask_q <= blank_mask;
        end
    end

`ifdef LED7SEG_SCAN_DP_EN
    // Capture the decimal-point bits alongside the data word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_dp_q <= '0;
        end else if (load) begin
            shadow_dp_q <= dp;
        end
    end
`endif

    // Prescaler, digit index and GAP/DRIVE next-state logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sample_en = 1'b0;
        presc_d   = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        case (state_q)
            GAP: begin
                if (presc_q == GAP_LAST) begin
                    state_d   = DRIVE;
                    sample_en = 1'b1;
                end
            end
            DRIVE: begin
                if (presc_q == PRESC_LAST) begin
                    state_d = GAP;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = GAP;
        endcase
    end

    // Scan control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GAP;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Select the shadow nibble and mask bit of the current digit.
    always_comb begin
        cur_nib  = 4'h0;
        cur_mask = 1'b0;
`ifdef LED7SEG_SCAN_DP_EN
        cur_dp   = 1'b0;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib  = shadow_data_q[4*k +: 4];
                cur_mask = shadow_mask_q[k];
`ifdef LED7SEG_SCAN_DP_EN
                cur_dp   = shadow_dp_q[k];
`endif
            end
        end
    end

    // Latch the digit to show on the last GAP cycle; held for the whole DRIVE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_nib_q  <= 4'h0;
            disp_mask_q <= 1'b0;
`ifdef LED7SEG_SCAN_DP_EN
            disp_dp_q   <= 1'b0;
`endif
        end else if (sample_en) begin
            disp_nib_q  <= cur_nib;
            disp_mask_q <= cur_mask;
`ifdef LED7SEG_SCAN_DP_EN
            disp_dp_q   <= cur_dp;
`endif
        end
    end

    assign drive_on = (state_q == DRIVE) && !disp_mask_q;

    led7seg_scan_decode #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_decode (
        .nibble_i (disp_nib_q),
        .enable_i (drive_on),
        .seg_o    (segments_d)
    );

    // One-hot digit enable at pin polarity (plus dp when present).
    always_comb begin
        digit_sel_d = DIG_OFF;
        for (int k = 0; k < DIGITS; k++) begin
            digit_sel_d[k] = (drive_on && (idx_q == IW'(k))) ^ DIG_OFF[k];
        end
`ifdef LED7SEG_SCAN_DP_EN
        seg_dp_d = (drive_on && disp_dp_q) ^ SEG_POL_LOW;
`endif
    end

    // Output pin registers; reset forces every pin inactive at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments_q  <= SEG_DARK;
            digit_sel_q <= DIG_OFF;
`ifdef LED7SEG_SCAN_DP_EN
            seg_dp_q    <= SEG_POL_LOW;
`endif
        end else begin
            segments_q  <= segments_d;
            digit_sel_q <= digit_sel_d;
`ifdef LED7SEG_SCAN_DP_EN
            seg_dp_q    <= seg_dp_d;
`endif
        end
    end

    assign segments  = segments_q;
    assign digit_sel = digit_sel_q;
`ifdef LED7SEG_SCAN_DP_EN
    assign seg_dp    = seg_dp_q;
`endif

endmodule

// File: tb/tb_led7seg_scan.sv
// tb_led7seg_scan: table-driven bench for led7seg_scan (default parameters).
// Expected pin values are queued per slot and compared at the exact edge.
module tb_led7seg_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 1024;
`ifdef LED7SEG_SCAN_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  blank_mask = '0;
    logic [6:0]  segments;
    logic [3:0]  digit_sel;
    logic        seg_dp_v;
`ifdef LED7SEG_SCAN_DP_EN
    logic [3:0]  dp = '0;
    logic        seg_dp;
    assign seg_dp_v = seg_dp;
`else
    assign seg_dp_v = 1'b1;
`endif

    int errors = 0;
    int checks = 0;
    int unsigned ecnt;

    always #5 clk = ~clk;

    led7seg_scan #(
        .DIGITS         (DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .GAP_CYCLES     (16),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data       (data),
        .blank_mask (blank_mask),
        .segments   (segments),
        .digit_sel  (digit_sel)
`ifdef LED7SEG_SCAN_DP_EN
        ,
        .dp         (dp),
        .seg_dp     (seg_dp)
`endif
    );

    // Active-high glyphs g..a for 0..F.
    logic [6:0] ah_tab [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                  7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    typedef struct {
        int unsigned at;
        logic [6:0]  seg;
        logic [3:0]  sel;
        logic        dpp;
        string       nm;
    } exp_t;

    typedef struct {
        int         digit;
        int         ch;
        bit         masked;
        bit         dp_lit;
        bit         do_load;
        int         load_off;
        logic [15:0] ld_data;
        logic [3:0]  ld_mask;
        logic [3:0]  ld_dp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[14];

    // Rising edges since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic check(input string nm, input logic [6:0] es, input logic [3:0] el, input logic edp);
        checks++;
        if (segments !== es || digit_sel !== el || seg_dp_v !== edp) begin
            errors++;
            $display("FAIL %s: got seg=%b sel=%b dp=%b, want seg=%b sel=%b dp=%b",
                     nm, segments, digit_sel, seg_dp_v, es, el, edp);
        end
    endtask

    task automatic push(input int unsigned at, input logic [6:0] s, input logic [3:0] l, input logic d, input string nm);
        exp_t e;
        e.at = at; e.seg = s; e.sel = l; e.dpp = d; e.nm = nm;
        sb.push_back(e);
    endtask

    // Queue gap and drive expectations for one slot starting at edge count base.
    task automatic push_slot(input int s, input int unsigned base, input int digit, input int ch,
                             input bit masked, input bit dp_lit);
        logic [3:0] one;
        logic [6:0] lseg;
        logic [3:0] lsel;
        logic       ldp;
        one  = 4'b0001;
        lseg = masked ? 7'h7F : ~ah_tab[ch];
        lsel = masked ? 4'hF : ~(one << digit);
        ldp  = (DP_EN && dp_lit && !masked) ? 1'b0 : 1'b1;
        push(base + 1,    7'h7F, 4'hF, 1'b1, $sformatf("slot%0d_gap_first", s));
        push(base + 16,   7'h7F, 4'hF, 1'b1, $sformatf("slot%0d_gap_last", s));
        push(base + 17,   lseg,  lsel, ldp,  $sformatf("slot%0d_drive_first", s));
        push(base + 520,  lseg,  lsel, ldp,  $sformatf("slot%0d_drive_mid", s));
        push(base + 1024, lseg,  lsel, ldp,  $sformatf("slot%0d_drive_last", s));
    endtask

    task automatic goto(input int unsigned n);
        int guard = 0;
        while (ecnt < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt < n) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout: at edge %0d, wanted edge %0d", ecnt, n);
        end
    endtask

    // Pulse load so it is captured on edge t.
    task automatic do_load(input int unsigned t, input logic [15:0] d, input logic [3:0] m, input logic [3:0] p);
        goto(t - 1);
        load = 1'b1; data = d; blank_mask = m;
`ifdef LED7SEG_SCAN_DP_EN
        dp = p;
`else
        if (p != 4'h0) data = d;
`endif
        goto(t);
        load = 1'b0;
    endtask

    // Scoreboard compare plus the one-hot-or-dark invariant on every cycle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(~digit_sel)) begin
            errors++;
            $display("FAIL sel_onehot0: got sel=%b at edge %0d, want at most one low", digit_sel, ecnt);
        end
        if (!reset) begin
            while (sb.size() > 0 && sb[0].at <= ecnt) begin
                mon_e = sb.pop_front();
                if (mon_e.at != ecnt) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: sampled at edge %0d, want edge %0d", mon_e.nm, ecnt, mon_e.at);
                end else begin
                    check(mon_e.nm, mon_e.seg, mon_e.sel, mon_e.dpp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        //            digit ch  mask dp   load off  data      mask     dp
        vecs[0]  = '{0, 4,   0, 1,   1,   3,  16'h1234, 4'b0000, 4'b0001};
        vecs[1]  = '{1, 3,   0, 0,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[2]  = '{2, 2,   0, 0,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[3]  = '{3, 1,   0, 0,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[4]  = '{0, 4,   0, 1,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[5]  = '{1, 3,   0, 0,   1, 400,  16'hABCD, 4'b0000, 4'b0001};
        vecs[6]  = '{2, 11,  0, 0,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[7]  = '{3, 10,  0, 0,   1, 600,  16'hABCD, 4'b0101, 4'b0001};
        vecs[8]  = '{0, 13,  1, 1,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[9]  = '{1, 12,  0, 0,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[10] = '{2, 11,  1, 0,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[11] = '{3, 10,  0, 0,   1, 500,  16'hABCD, 4'b0000, 4'b0001};
        vecs[12] = '{0, 13,  0, 1,   0,   0,  16'h0000, 4'b0000, 4'b0000};
        vecs[13] = '{1, 12,  0, 0,   1,  16,  16'h5678, 4'b0000, 4'b0001};

        repeat (3) @(negedge clk);
        check("reset_idle", 7'h7F, 4'hF, 1'b1);
        reset = 1'b0;

        for (int s = 0; s < 14; s++) begin
            base = s * SCAN_DIV;
            push_slot(s, base, vecs[s].digit, vecs[s].ch, vecs[s].masked, vecs[s].dp_lit);
            if (vecs[s].do_load)
                do_load(base + vecs[s].load_off, vecs[s].ld_data, vecs[s].ld_mask, vecs[s].ld_dp);
            goto(base + SCAN_DIV);
        end

        // Digit2 slot shows the data loaded on slot 13's sample edge, then reset mid-DRIVE.
        base = 14 * SCAN_DIV;
        push(base + 1,   7'h7F, 4'hF, 1'b1, "slot14_gap_first");
        push(base + 16,  7'h7F, 4'hF, 1'b1, "slot14_gap_last");
        push(base + 17,  ~ah_tab[6], 4'b1011, 1'b1, "slot14_drive_first");
        push(base + 315, ~ah_tab[6], 4'b1011, 1'b1, "slot14_drive_300");
        goto(base + 316);
        reset = 1'b1;
        #1;
        check("reset_async", 7'h7F, 4'hF, 1'b1);
        repeat (3) @(negedge clk);
        check("reset_hold", 7'h7F, 4'hF, 1'b1);
        reset = 1'b0;

        // Shadow cleared by reset: digits restart at 0 showing '0'.
        push_slot(100, 0, 0, 0, 0, 0);
        push_slot(101, SCAN_DIV, 1, 0, 0, 0);
        goto(2 * SCAN_DIV + 2);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
